// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: per-channel synchroniser, polarity normalisation, debounce filter,
// press/release pulses and long-press detection. Optional auto-repeat with DEBOUNCER_MULTI_REPEAT_EN.
module debouncer_multi #(
  parameter int                   CHANNELS        = 4,
  parameter logic [CHANNELS-1:0]  IDLE_LEVEL      = {CHANNELS{1'b1}},
  parameter int                   SYNC_STAGES     = 2,
  parameter int                   DEBOUNCE_CYCLES = 1000,
  parameter int                   HOLD_CYCLES     = 50000000,
  parameter int                   REPEAT_CYCLES   = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] press,
  // "release" is a reserved word, hence the suffix
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
`ifdef DEBOUNCER_MULTI_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
`endif

  if (CHANNELS < 1 || SYNC_STAGES < 1 || DEBOUNCE_CYCLES < 1 ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("debouncer_multi: all size parameters must be >= 1");
  end

  function automatic logic [HW-1:0] hold_step(input logic [HW-1:0] c);
    return (c == HW'(HOLD_CYCLES)) ? c : c + 1'b1;
  endfunction

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_p1;
    logic [DW-1:0]          db_cnt_p1;
    logic [HW-1:0]          hold_cnt_p2;
    logic                   pressed_r, press_r, release_r, long_r;
    logic                   toggle, hold_hit, hold_done, rpt_fire;

    // Stage p0: synchroniser chain, resting at the idle level
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_p0 <= {SYNC_STAGES{IDLE_LEVEL[g]}};
      end else begin
        sync_p0[0] <= in[g];
        for (int j = 1; j < SYNC_STAGES; j++) sync_p0[j] <= sync_p0[j-1];
      end
    end

    // Stage p1: normalised level and debounce filter; any return to stable clears the count
    assign s_p1   = sync_p0[SYNC_STAGES-1] ^ IDLE_LEVEL[g];
    assign toggle = (s_p1 != pressed_r) && (db_cnt_p1 == DW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt_p1 <= '0;
        pressed_r <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        press_r   <= toggle & ~pressed_r;
        release_r <= toggle & pressed_r;
        if (s_p1 == pressed_r) begin
          db_cnt_p1 <= '0;
        end else if (toggle) begin
          db_cnt_p1 <= '0;
          pressed_r <= ~pressed_r;
        end else begin
          db_cnt_p1 <= db_cnt_p1 + 1'b1;
        end
      end
    end

    // Stage p2: hold timer, saturating at HOLD_CYCLES so long_press fires once per press
    assign hold_done = (hold_cnt_p2 == HW'(HOLD_CYCLES));
    assign hold_hit  = pressed_r && !toggle && (hold_cnt_p2 == HW'(HOLD_CYCLES - 1));

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_cnt_p2 <= '0;
        long_r      <= 1'b0;
      end else begin
        long_r <= hold_hit | rpt_fire;
        if (toggle || !pressed_r) hold_cnt_p2 <= '0;
        else                      hold_cnt_p2 <= hold_step(hold_cnt_p2);
      end
    end

`ifdef DEBOUNCER_MULTI_REPEAT_EN
    logic [RW-1:0] rpt_cnt_p2;
    assign rpt_fire = pressed_r && !toggle && hold_done &&
                      (rpt_cnt_p2 == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk) begin
      if (rst || toggle || !pressed_r || !hold_done) rpt_cnt_p2 <= '0;
      else if (rpt_cnt_p2 == RW'(REPEAT_CYCLES - 1)) rpt_cnt_p2 <= '0;
      else rpt_cnt_p2 <= rpt_cnt_p2 + 1'b1;
    end
`else
    logic unused_done;
    assign unused_done = hold_done;
    assign rpt_fire    = 1'b0;
`endif

    assign pressed[g]       = pressed_r;
    assign press[g]         = press_r;
    assign release_pulse[g] = release_r;
    assign long_press[g]    = long_r;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench for debouncer_multi: stimulus queues expected pulse events by edge number,
// a negedge monitor matches every DUT pulse against the queue.
module tb_debouncer_multi;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic [3:0] pressed, press, release_pulse, long_press;

  int n_vec  = 0;
  int n_fail = 0;
  int edge_n = 0;

  typedef struct {
    int         cyc;
    logic [3:0] pr, rl, lp, pd;
  } ev_t;

  ev_t sb[$];

  debouncer_multi #(
    .CHANNELS(4), .IDLE_LEVEL(4'b0111), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16), .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .pressed(pressed), .press(press),
    .release_pulse(release_pulse), .long_press(long_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic push_ev(input int cyc, input logic [3:0] pr, input logic [3:0] rl,
                         input logic [3:0] lp, input logic [3:0] pd);
    ev_t e;
    int  i;
    e.cyc = cyc; e.pr = pr; e.rl = rl; e.lp = lp; e.pd = pd;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= cyc) i++;
    sb.insert(i, e);
  endtask

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b expected %b", nm, edge_n, got, exp);
    end
  endtask

  // Monitor: every cycle with a pulse must match the earliest queued event exactly
  always @(negedge clk) begin
    ev_t e;
    while (sb.size() > 0 && sb[0].cyc < edge_n) begin
      e = sb.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL missing_event: expected at edge %0d press=%b release=%b long=%b, not observed",
               e.cyc, e.pr, e.rl, e.lp);
    end
    if ((press | release_pulse | long_press) != 4'b0) begin
      n_vec++;
      if (sb.size() == 0 || sb[0].cyc != edge_n) begin
        n_fail++;
        $display("FAIL unexpected_pulse at edge %0d: press=%b release=%b long=%b, expected none",
                 edge_n, press, release_pulse, long_press);
      end else begin
        e = sb.pop_front();
        if (press !== e.pr || release_pulse !== e.rl || long_press !== e.lp || pressed !== e.pd) begin
          n_fail++;
          $display("FAIL event_edge%0d: got press=%b release=%b long=%b pressed=%b expected %b %b %b %b",
                   edge_n, press, release_pulse, long_press, pressed, e.pr, e.rl, e.lp, e.pd);
        end
      end
    end
  end

  initial begin
    int r_e;
    rst = 1'b1;
    in  = 4'b0111;

    // Reset and idle
    repeat (5) @(negedge clk);
    chk("reset_pressed", pressed, 4'b0000);
    chk("reset_pulses", press | release_pulse | long_press, 4'b0000);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_pressed", pressed, 4'b0000);

    // All channels active during reset: nothing happens
    rst = 1'b1;
    in  = 4'b1000;
    repeat (20) @(negedge clk);
    chk("rst_active_pressed", pressed, 4'b0000);
    in = 4'b0111;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Channel 0 active-low press and release
    in = 4'b0110;
    push_ev(edge_n + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    repeat (4) @(negedge clk);
    chk("ch0_before_press", pressed, 4'b0000);
    repeat (5) @(negedge clk);
    chk("ch0_held", pressed, 4'b0001);
    in = 4'b0111;
    push_ev(edge_n + 6, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    repeat (12) @(negedge clk);
    chk("ch0_after_release", pressed, 4'b0000);

    // Channel 1 bounces with 3-cycle phases: never accepted
    for (int i = 0; i < 7; i++) begin
      in = 4'b0101;
      repeat (3) @(negedge clk);
      in = 4'b0111;
      repeat (3) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("ch1_bounce_pressed", pressed, 4'b0000);

    // Channel 3 active-high long press
    in = 4'b1111;
    push_ev(edge_n + 6,  4'b1000, 4'b0000, 4'b0000, 4'b1000);
    push_ev(edge_n + 22, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
`ifdef DEBOUNCER_MULTI_REPEAT_EN
    push_ev(edge_n + 30, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
    push_ev(edge_n + 38, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
    push_ev(edge_n + 46, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
`endif
    repeat (45) @(negedge clk);
    chk("ch3_held", pressed, 4'b1000);
    in = 4'b0111;
    push_ev(edge_n + 6, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    repeat (12) @(negedge clk);

    // Channels 0 and 2 together, then reset mid-hold
    in = 4'b0010;
    push_ev(edge_n + 6, 4'b0101, 4'b0000, 4'b0000, 4'b0101);
    repeat (16) @(negedge clk);
    chk("ch02_held", pressed, 4'b0101);
    rst = 1'b1;
    @(negedge clk);
    chk("midhold_rst_pressed", pressed, 4'b0000);
    chk("midhold_rst_press", press, 4'b0000);
    chk("midhold_rst_release", release_pulse, 4'b0000);
    chk("midhold_rst_long", long_press, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r_e = edge_n;
    push_ev(r_e + 6,  4'b0101, 4'b0000, 4'b0000, 4'b0101);
    push_ev(r_e + 22, 4'b0000, 4'b0000, 4'b0101, 4'b0101);
`ifdef DEBOUNCER_MULTI_REPEAT_EN
    push_ev(r_e + 30, 4'b0000, 4'b0000, 4'b0101, 4'b0101);
`endif
    repeat (25) @(negedge clk);
    in = 4'b0111;
    push_ev(edge_n + 6, 4'b0000, 4'b0101, 4'b0000, 4'b0000);
    repeat (15) @(negedge clk);
    chk("final_pressed", pressed, 4'b0000);

    while (sb.size() > 0) begin
      ev_t e;
      e = sb.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL leftover_event: edge %0d press=%b release=%b long=%b never seen",
               e.cyc, e.pr, e.rl, e.lp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
